// File: rtl/qs_srt_fetch.sv
// qs_srt instruction fetch front-end: PC sequencing, 1-cycle imem, 2-entry out FIFO.
// Optional perf counters are built when QS_SRT_FETCH_PERF_EN is defined.
package qs_srt_pkg;
    typedef logic [15:0] inst_t;
endpackage

module qs_srt_fetch
    import qs_srt_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    input  logic            stop,
    input  logic            redirect_vld,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_ren,
    output logic [PC_W-1:0] imem_raddr,
    input  inst_t           imem_rdata,
    output logic            fetch_vld,
    input  logic            fetch_rdy,
    output inst_t           fetch_inst,
    output logic [PC_W-1:0] fetch_pc,
    output logic            busy,
    output logic [31:0]     perf_inst_cnt,
    output logic [31:0]     perf_stall_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]      state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] rd_pc;
    logic            inflight;
    logic            kill;

    inst_t           fifo_inst [2];
    logic [PC_W-1:0] fifo_pc   [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      count;

    logic            run;
    logic            flush;
    logic            pop;
    logic            wr;
    logic [2:0]      occ;

    assign run   = (state == S_RUN);
    assign flush = run & (stop | redirect_vld);
    assign pop   = fetch_vld & fetch_rdy;
    assign occ   = {1'b0, count} + {2'b0, inflight};

    // Issue only when the FIFO is guaranteed a free slot for the return.
    assign imem_ren   = run & ~stop & ~redirect_vld
                      & (occ < (3'd2 + {2'b0, pop}));
    assign imem_raddr = pc;

    assign wr         = inflight & ~kill & ~flush;
    assign fetch_vld  = (count != 2'd0);
    assign fetch_inst = fifo_inst[rd_ptr];
    assign fetch_pc   = fifo_pc[rd_ptr];
    assign busy       = run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
        end else if (!run) begin
            if (start) begin
                state <= S_RUN;
                pc    <= start_pc;
            end
        end else if (stop) begin
            state <= S_IDLE;
        end else if (redirect_vld) begin
            pc <= redirect_pc;
        end else if (imem_ren) begin
            pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            kill     <= 1'b0;
            rd_pc    <= '0;
        end else begin
            inflight <= imem_ren;
            kill     <= flush;
            if (imem_ren) begin
                rd_pc <= pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr) begin
                fifo_inst[wr_ptr] <= imem_rdata;
                fifo_pc[wr_ptr]   <= rd_pc;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, wr} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(wr && count == 2'd2));
        end
    end

`ifdef QS_SRT_FETCH_PERF_EN
    logic [31:0] inst_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop) begin
                inst_cnt <= inst_cnt + 32'd1;
            end
            if (fetch_vld & ~fetch_rdy) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_inst_cnt  = inst_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_inst_cnt  = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_qs_srt_fetch.sv
// Self-checking bench for qs_srt_fetch: directed vector table, then random
// stimulus against a stream-level scoreboard, then reset and wrap sequences.
module tb_qs_srt_fetch;
    import qs_srt_pkg::*;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] start_pc;
    logic         stop;
    logic         redirect_vld;
    logic [W-1:0] redirect_pc;
    logic         imem_ren;
    logic [W-1:0] imem_raddr;
    inst_t        imem_rdata;
    logic         fetch_vld;
    logic         fetch_rdy;
    inst_t        fetch_inst;
    logic [W-1:0] fetch_pc;
    logic         busy;
    logic [31:0]  perf_inst_cnt;
    logic [31:0]  perf_stall_cnt;

    always #5 clk = ~clk;

    qs_srt_fetch #(.PC_W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_pc      (start_pc),
        .stop          (stop),
        .redirect_vld  (redirect_vld),
        .redirect_pc   (redirect_pc),
        .imem_ren      (imem_ren),
        .imem_raddr    (imem_raddr),
        .imem_rdata    (imem_rdata),
        .fetch_vld     (fetch_vld),
        .fetch_rdy     (fetch_rdy),
        .fetch_inst    (fetch_inst),
        .fetch_pc      (fetch_pc),
        .busy          (busy),
        .perf_inst_cnt (perf_inst_cnt),
        .perf_stall_cnt(perf_stall_cnt)
    );

    function automatic inst_t mem_word(input logic [W-1:0] a);
        return {a[5:0], a} ^ 16'hA5C3;
    endfunction

    // Synchronous memory; garbage on non-read cycles exposes stray writes.
    always @(posedge clk) begin
        if (imem_ren) imem_rdata <= mem_word(imem_raddr);
        else          imem_rdata <= inst_t'($urandom);
    end

    typedef struct {
        logic         start;
        logic [W-1:0] spc;
        logic         rdy;
        logic         redir;
        logic [W-1:0] rpc;
        logic         stop;
        logic         ren;
        logic [W-1:0] raddr;
        logic         vld;
        logic [W-1:0] pc;
        logic         busy;
    } vec_t;

    function automatic vec_t mk(
        input logic st, input logic [W-1:0] spc, input logic rdy,
        input logic rd, input logic [W-1:0] rpc, input logic sp,
        input logic ren, input logic [W-1:0] ra, input logic vld,
        input logic [W-1:0] pc, input logic bz);
        vec_t v;
        v.start = st; v.spc = spc; v.rdy = rdy;
        v.redir = rd; v.rpc = rpc; v.stop = sp;
        v.ren = ren; v.raddr = ra; v.vld = vld;
        v.pc = pc; v.busy = bz;
        return v;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Stream-level reference: accepted pcs form a run from the last
    // start/redirect target; a stalled head must hold.
    bit           m_run;
    logic [W-1:0] exp_pc;
    int           m_inst;
    int           m_stall;
    int           hs_total;
    bit           hold_exp;
    logic [W-1:0] hold_pc;
    inst_t        hold_inst;

    task automatic check_cycle();
        if (hold_exp) begin
            chk("hold_vld", 32'(fetch_vld), 32'd1);
            chk("hold_pc", 32'(fetch_pc), 32'(hold_pc));
            chk("hold_inst", 32'(fetch_inst), 32'(hold_inst));
        end
        chk("busy", 32'(busy), 32'(m_run));
        if (!m_run) begin
            chk("idle_ren", 32'(imem_ren), 32'd0);
            chk("idle_vld", 32'(fetch_vld), 32'd0);
        end
        if (fetch_vld && fetch_rdy) begin
            chk("hs_pc", 32'(fetch_pc), 32'(exp_pc));
            chk("hs_inst", 32'(fetch_inst), 32'(mem_word(exp_pc)));
            exp_pc = exp_pc + 1'b1;
            m_inst++;
            hs_total++;
        end
        if (fetch_vld && !fetch_rdy) m_stall++;
        hold_exp  = fetch_vld && !fetch_rdy && m_run
                  && !stop && !redirect_vld;
        hold_pc   = fetch_pc;
        hold_inst = fetch_inst;
        if (m_run) begin
            if (stop) m_run = 1'b0;
            else if (redirect_vld) exp_pc = redirect_pc;
        end else if (start) begin
            m_run  = 1'b1;
            exp_pc = start_pc;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_perf(input string nm, input int ei, input int es);
`ifdef QS_SRT_FETCH_PERF_EN
        chk({nm, "_inst"}, perf_inst_cnt, ei);
        chk({nm, "_stall"}, perf_stall_cnt, es);
`else
        chk({nm, "_inst"}, perf_inst_cnt, 32'd0);
        chk({nm, "_stall"}, perf_stall_cnt, 32'd0);
`endif
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_ren"}, 32'(imem_ren), 32'd0);
        chk({nm, "_raddr"}, 32'(imem_raddr), 32'd0);
        chk({nm, "_vld"}, 32'(fetch_vld), 32'd0);
        chk({nm, "_pc"}, 32'(fetch_pc), 32'd0);
        chk({nm, "_inst"}, 32'(fetch_inst), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_pinst"}, perf_inst_cnt, 32'd0);
        chk({nm, "_pstall"}, perf_stall_cnt, 32'd0);
    endtask

    vec_t tbl [25];
    int   hs_mark;

    initial begin
        tbl[0]  = mk(1, 'h010, 1, 0, 0, 0, 0, 0,     0, 0,     0);
        tbl[1]  = mk(0, 0,     1, 0, 0, 0, 1, 'h010, 0, 0,     1);
        tbl[2]  = mk(0, 0,     1, 0, 0, 0, 1, 'h011, 0, 0,     1);
        tbl[3]  = mk(0, 0,     1, 0, 0, 0, 1, 'h012, 1, 'h010, 1);
        tbl[4]  = mk(0, 0,     1, 0, 0, 0, 1, 'h013, 1, 'h011, 1);
        for (int i = 5; i <= 10; i++)
            tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h012, 1);
        tbl[11] = mk(0, 0,     1, 0, 0,     0, 1, 'h014, 1, 'h012, 1);
        tbl[12] = mk(0, 0,     1, 0, 0,     0, 1, 'h015, 1, 'h013, 1);
        tbl[13] = mk(0, 0,     1, 0, 0,     0, 1, 'h016, 1, 'h014, 1);
        tbl[14] = mk(0, 0,     0, 1, 'h040, 0, 0, 0,     1, 'h015, 1);
        tbl[15] = mk(0, 0,     1, 0, 0,     0, 1, 'h040, 0, 0,     1);
        tbl[16] = mk(0, 0,     1, 0, 0,     0, 1, 'h041, 0, 0,     1);
        tbl[17] = mk(0, 0,     1, 0, 0,     0, 1, 'h042, 1, 'h040, 1);
        tbl[18] = mk(0, 0,     1, 0, 0,     0, 1, 'h043, 1, 'h041, 1);
        tbl[19] = mk(0, 0,     1, 0, 0,     1, 0, 0,     1, 'h042, 1);
        tbl[20] = mk(0, 0,     1, 1, 'h100, 0, 0, 0,     0, 0,     0);
        tbl[21] = mk(1, 'h020, 1, 0, 0,     0, 0, 0,     0, 0,     0);
        tbl[22] = mk(0, 0,     1, 0, 0,     0, 1, 'h020, 0, 0,     1);
        tbl[23] = mk(0, 0,     1, 0, 0,     0, 1, 'h021, 0, 0,     1);
        tbl[24] = mk(0, 0,     1, 0, 0,     0, 1, 'h022, 1, 'h020, 1);

        m_run = 0; exp_pc = '0; m_inst = 0; m_stall = 0;
        hs_total = 0; hold_exp = 0; hold_pc = '0; hold_inst = '0;

        rst_n = 1'b0; start = 0; start_pc = '0; stop = 0;
        redirect_vld = 0; redirect_pc = '0; fetch_rdy = 0;
        #12;
        chk_reset_outs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            start        = tbl[i].start;
            start_pc     = tbl[i].spc;
            fetch_rdy    = tbl[i].rdy;
            redirect_vld = tbl[i].redir;
            redirect_pc  = tbl[i].rpc;
            stop         = tbl[i].stop;
            @(negedge clk);
            chk($sformatf("row%0d_ren", i), 32'(imem_ren), 32'(tbl[i].ren));
            if (tbl[i].ren)
                chk($sformatf("row%0d_raddr", i), 32'(imem_raddr),
                    32'(tbl[i].raddr));
            chk($sformatf("row%0d_vld", i), 32'(fetch_vld), 32'(tbl[i].vld));
            if (tbl[i].vld)
                chk($sformatf("row%0d_pc", i), 32'(fetch_pc), 32'(tbl[i].pc));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            if (i == 11) chk_perf("perf_bp", 2, 6);
            check_cycle();
            @(posedge clk);
            #1;
        end
        chk_perf("perf_tbl", 9, 7);

        hs_mark = hs_total;
        for (int c = 0; c < 3000; c++) begin
            start        = ($urandom_range(0, 99) < 30);
            start_pc     = W'($urandom);
            stop         = ($urandom_range(0, 99) < 2);
            redirect_vld = ($urandom_range(0, 99) < 6);
            redirect_pc  = W'($urandom);
            fetch_rdy    = ($urandom_range(0, 99) < 65);
            step();
        end
        chk("rand_progress", 32'(hs_total - hs_mark > 300), 32'd1);
        chk_perf("perf_rand", m_inst, m_stall);

        stop = 0; redirect_vld = 0; fetch_rdy = 1;
        if (m_run) begin
            stop = 1;
            step();
            stop = 0;
        end
        start = 1; start_pc = 'h200;
        step();
        start = 0;
        for (int c = 0; c < 5; c++) step();
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("mid_rst");
        m_run = 0; m_inst = 0; m_stall = 0; hold_exp = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        redirect_vld = 1; redirect_pc = 'h055;
        for (int c = 0; c < 4; c++) step();
        redirect_vld = 0;

        hs_mark = hs_total;
        start = 1; start_pc = 'h3FE;
        step();
        start = 0;
        for (int c = 0; c < 7; c++) step();
        chk("wrap_hs", 32'(hs_total - hs_mark), 32'd5);
        chk_perf("perf_wrap", 5, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
